// File: rtl/sunsoft5b_env_noise.sv
// Sunsoft 5B envelope generator and 17-bit noise LFSR with CPU register port.
// Level output is registered one clk behind the envelope state.
module sunsoft5b_env_noise (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        wr,
  input  logic [15:0] ain,
  input  logic [7:0]  din,
  output logic [4:0]  env_level,
  output logic        noise_out,
  output logic        env_active
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  logic [3:0]  sel;
  logic [4:0]  noise_period;
  logic [15:0] env_period;
  logic [3:0]  shape;
  logic [3:0]  presc;
  logic [4:0]  ncnt;
  logic        half;
  logic [16:0] lfsr;
  logic [15:0] ecnt;

  state_t      state, state_nxt;
  logic [4:0]  step, step_nxt;
  logic [4:0]  held, held_nxt;
  logic        dir, dir_nxt;
  logic [4:0]  level_nxt;
  logic [4:0]  level_p1;

  logic        wr_sel, wr_data, shape_wr, tick;
  logic [4:0]  n_per;
  logic [15:0] e_per;
  logic        n_wrap, e_wrap, step_evt;
  logic        unused_addr;

  assign unused_addr = ^ain[12:0];

  assign wr_sel   = ce && wr && (ain[15:13] == 3'b110);
  assign wr_data  = ce && wr && (ain[15:13] == 3'b111);
  assign shape_wr = wr_data && (sel == 4'd13);
  assign tick     = ce && (presc == 4'hF);

  // A zero period behaves as one so both counters still wrap every tick.
  assign n_per    = (noise_period == 5'd0) ? 5'd1 : noise_period;
  assign e_per    = (env_period == 16'd0) ? 16'd1 : env_period;
  assign n_wrap   = ({1'b0, ncnt} + 6'd1) >= {1'b0, n_per};
  assign e_wrap   = ({1'b0, ecnt} + 17'd1) >= {1'b0, e_per};
  assign step_evt = tick && e_wrap;

  // Register file, prescaler and the noise / envelope period counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel          <= 4'd0;
      noise_period <= 5'd0;
      env_period   <= 16'd0;
      shape        <= 4'd0;
      presc        <= 4'd0;
      ncnt         <= 5'd0;
      half         <= 1'b0;
      lfsr         <= 17'h00001;
      ecnt         <= 16'd0;
    end else begin
      if (ce)
        presc <= presc + 4'd1;
      if (wr_sel)
        sel <= din[3:0];
      if (wr_data) begin
        case (sel)
          4'd6:    noise_period     <= din[4:0];
          4'd11:   env_period[7:0]  <= din;
          4'd12:   env_period[15:8] <= din;
          4'd13:   shape            <= din[3:0];
          default: ;
        endcase
      end
      if (tick) begin
        if (n_wrap) begin
          ncnt <= 5'd0;
          half <= ~half;
          if (!half)
            lfsr <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
        end else begin
          ncnt <= ncnt + 5'd1;
        end
      end
      if (shape_wr)
        ecnt <= 16'd0;
      else if (tick)
        ecnt <= e_wrap ? 16'd0 : ecnt + 16'd1;
    end
  end

  // Envelope FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= HOLD;
      step  <= 5'd0;
      held  <= 5'd0;
      dir   <= 1'b0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
      held  <= held_nxt;
      dir   <= dir_nxt;
    end
  end

  // Shape bits are {C, Att, Alt, Hold}; a shape write outranks a step event.
  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    held_nxt  = held;
    dir_nxt   = dir;
    if (shape_wr) begin
      state_nxt = RUN;
      step_nxt  = 5'd0;
      dir_nxt   = din[2];
    end else if (step_evt && (state == RUN)) begin
      if (step != 5'd31) begin
        step_nxt = step + 5'd1;
      end else if (!shape[3]) begin
        state_nxt = HOLD;
        held_nxt  = 5'd0;
      end else if (shape[0]) begin
        state_nxt = HOLD;
        held_nxt  = (shape[2] ^ shape[1]) ? 5'd31 : 5'd0;
      end else begin
        step_nxt = 5'd0;
        if (shape[1])
          dir_nxt = ~dir;
      end
    end
  end

  always_comb begin
    env_active = (state == RUN);
    level_nxt  = held;
    if (state == RUN)
      level_nxt = dir ? step : (5'd31 - step);
  end

  // Output stage: level registered one clk after the state that produced it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      level_p1 <= 5'd0;
    else
      level_p1 <= level_nxt;
  end

  assign env_level = level_p1;
  assign noise_out = lfsr[0];

endmodule

// File: tb/tb_sunsoft5b_env_noise.sv
// Directed bench for sunsoft5b_env_noise: reset values, noise LFSR timing,
// envelope ramp / decay / triangle shapes, shape-write priority and async reset.
module tb_sunsoft5b_env_noise;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        ce = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] ain = 16'h0000;
  logic [7:0]  din = 8'h00;
  logic [4:0]  env_level;
  logic        noise_out;
  logic        env_active;

  int          vectors = 0;
  int          miscompares = 0;
  int          n = 0;
  logic [16:0] m;

  sunsoft5b_env_noise dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce         (ce),
    .wr         (wr),
    .ain        (ain),
    .din        (din),
    .env_level  (env_level),
    .noise_out  (noise_out),
    .env_active (env_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One ce cycle; n counts ce cycles since reset release.
  task automatic clk1(input logic w, input logic [15:0] a, input logic [7:0] d);
    ce  = 1'b1;
    wr  = w;
    ain = a;
    din = d;
    @(posedge clk);
    #1;
    n++;
    wr = 1'b0;
  endtask

  task automatic run_to(input int target);
    while (n < target) clk1(1'b0, 16'h0000, 8'h00);
  endtask

  task automatic wreg(input logic [3:0] r, input logic [7:0] v);
    clk1(1'b1, 16'hC000, {4'h0, r});
    clk1(1'b1, 16'hE000, v);
  endtask

  task automatic lvl_at(input string tag, input int t, input int exp);
    run_to(t);
    check(tag, 32'(env_level), exp);
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    ce = 1'b0;
    wr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    n = 0;
  endtask

  initial begin
    // Reset output values
    #3 reset_n = 1'b0;
    #1;
    check("rst_level", 32'(env_level), 0);
    check("rst_noise", 32'(noise_out), 1);
    check("rst_active", 32'(env_active), 0);
    do_reset();

    // Noise, period 0: LFSR shifts on ce 16, 48, 80, ...
    m = 17'h00001;
    for (int k = 0; k < 20; k++) begin
      run_to(15 + 32 * k);
      check("noise_pre", 32'(noise_out), 32'(m[0]));
      clk1(1'b0, 16'h0000, 8'h00);
      m = {m[0] ^ m[3], m[16:1]};
      check("noise_post", 32'(noise_out), 32'(m[0]));
    end

    // Sawtooth up: period 1, shape C,Att
    do_reset();
    wreg(4'd11, 8'd1);
    wreg(4'd12, 8'd0);
    wreg(4'd13, 8'h0C);
    check("saw_active", 32'(env_active), 1);
    lvl_at("saw_n7", 7, 0);
    lvl_at("saw_n17", 17, 1);
    lvl_at("saw_n32", 32, 1);
    lvl_at("saw_n33", 33, 2);
    lvl_at("saw_n497", 497, 31);
    lvl_at("saw_n512", 512, 31);
    lvl_at("saw_n513", 513, 0);
    lvl_at("saw_n529", 529, 1);

    // Decay then hold at 0: period 2, shape C,Hold
    do_reset();
    wreg(4'd11, 8'd2);
    wreg(4'd12, 8'd0);
    wreg(4'd13, 8'h09);
    lvl_at("dec_n7", 7, 31);
    lvl_at("dec_n32", 32, 31);
    lvl_at("dec_n33", 33, 30);
    lvl_at("dec_n65", 65, 29);
    lvl_at("dec_n992", 992, 1);
    lvl_at("dec_n993", 993, 0);
    check("dec_active_993", 32'(env_active), 1);
    run_to(1023);
    check("dec_active_1023", 32'(env_active), 1);
    run_to(1024);
    check("dec_active_1024", 32'(env_active), 0);
    lvl_at("dec_n1025", 1025, 0);
    lvl_at("dec_n2100", 2100, 0);
    check("dec_active_2100", 32'(env_active), 0);

    // Triangle: period 1, shape C,Att,Alt
    do_reset();
    wreg(4'd11, 8'd1);
    wreg(4'd12, 8'd0);
    wreg(4'd13, 8'h0E);
    lvl_at("tri_n497", 497, 31);
    lvl_at("tri_n513", 513, 31);
    lvl_at("tri_n529", 529, 30);
    lvl_at("tri_n1009", 1009, 0);
    lvl_at("tri_n1025", 1025, 0);
    lvl_at("tri_n1041", 1041, 1);

    // Shape write landing on a step-event ce (n=1056) discards the event
    run_to(1054);
    clk1(1'b1, 16'hC000, 8'd13);
    check("prio_n1055", 32'(env_level), 1);
    clk1(1'b1, 16'hE000, 8'h0D);
    check("prio_n1056", 32'(env_level), 1);
    lvl_at("prio_n1057", 1057, 0);
    check("prio_active", 32'(env_active), 1);
    lvl_at("prio_n1072", 1072, 0);
    lvl_at("prio_n1073", 1073, 1);

    // Lowering the period below the count wraps on the next tick
    do_reset();
    wreg(4'd11, 8'hFF);
    wreg(4'd12, 8'hFF);
    wreg(4'd13, 8'h0C);
    lvl_at("per_n1600", 1600, 0);
    wreg(4'd11, 8'd50);
    wreg(4'd12, 8'd0);
    lvl_at("per_n1616", 1616, 0);
    lvl_at("per_n1617", 1617, 1);
    lvl_at("per_n2416", 2416, 1);
    lvl_at("per_n2417", 2417, 2);
    check("per_active", 32'(env_active), 1);

    // Asynchronous reset mid-ramp, sampled before any clk edge
    #3 reset_n = 1'b0;
    #1;
    check("async_level", 32'(env_level), 0);
    check("async_active", 32'(env_active), 0);
    check("async_noise", 32'(noise_out), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
